qconv_read_indata: RTL and testbench
====================================

# qconv_read_indata

Input-tile fetch engine for the quantized convolution loop nest. It is started once per (ih_high, iw_high) iteration by the ihw_high loop controller. It reads a TileH×TileW tile of packed input words from external memory into the on-chip input buffer, substituting zeros for padding positions. It pulses `finish` when the last word is written, which the controller consumes as its read-indata completion.

## Interface
- `TileH`, default 4: tile rows.
- `TileW`, default 4: tile columns.
- `InH`, default 8: input feature-map height, in words.
- `InW`, default 8: input feature-map width, in words.
- `Pad`, default 1: zero-padding on each border, in words.
- `HighBitWidth`, default 4: width of `ih_high` and `iw_high`.
- `AddrWidth`, default 32: memory word-address width.
- `DataWidth`, default 64: packed input word width.
- `BufAddrWidth`, default $clog2(TileH*TileW): input buffer address width.
- `MaxOutstanding`, default 8: depth of the in-flight tag FIFO. Must be a power of two.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle start pulse. Ignored unless the block is IDLE.
- `ih_high` in HighBitWidth: tile row index. Sampled on accepted `start`.
- `iw_high` in HighBitWidth: tile column index. Sampled on accepted `start`.
- `base_addr` in AddrWidth: word address of input element (0,0). Sampled on accepted `start`.
- `rd_req_valid` out 1: read request valid.
- `rd_req_ready` in 1: memory accepts the request.
- `rd_req_addr` out AddrWidth: read word address.
- `rd_rsp_valid` in 1: read data valid. Responses return in request order.
- `rd_rsp_ready` out 1: block accepts the response.
- `rd_rsp_data` in DataWidth: read data.
- `buf_we` out 1: input buffer write enable.
- `buf_addr` out BufAddrWidth: buffer address, r*TileW+c.
- `buf_wdata` out DataWidth: buffer write data.
- `finish` out 1: one-cycle completion pulse.

## Operation
- Element (r,c), where 0≤r<TileH and 0≤c<TileW, maps to:
  - row = ih_high*TileH + r − Pad
  - col = iw_high*TileW + c − Pad
- Row and column are computed signed, at width HighBitWidth+$clog2(max(TileH,TileW))+2.
- An element is padding if row<0, row≥InH, col<0 or col≥InW.
- Otherwise its address is base_addr + row*InW + col, truncated to AddrWidth.
- Elements are issued in raster order: c is the inner loop, r is the outer loop.
- Issue side, one element per cycle at most:
  - Padding element: enqueue {pad=1, buf_addr} when the FIFO is not full. No request is issued.
  - Real element: assert `rd_req_valid` when the FIFO is not full. Enqueue {pad=0, buf_addr} on `rd_req_valid && rd_req_ready`.
- Retire side, in FIFO order:
  - Head is padding: write zero that cycle and pop.
  - Head is real: `rd_rsp_ready`=1. On `rd_rsp_valid`, write `rd_rsp_data` and pop.
- FSM states:
  - IDLE: on `start`, latch the inputs and go to ISSUE.
  - ISSUE: when the last element is enqueued, go to DRAIN.
  - DRAIN: when the FIFO is empty and the last write is done, go to DONE.
  - DONE: `finish`=1, then go to IDLE.
- Full FIFO: issue stalls. `rd_req_valid` stays high, with stable address, until the handshake completes.
- Simultaneous enqueue and pop on a full FIFO is allowed.
- Reset values: `rd_req_valid`, `rd_rsp_ready`, `buf_we` and `finish` are all 0. `buf_addr`, `buf_wdata` and `rd_req_addr` are 0. State is IDLE, FIFO is empty.
- Reset mid-operation: the block returns to IDLE and `finish` is not pulsed. The memory side must be reset together with this block; stale responses are not tolerated.

## Timing
- The accepted `start` cycle N latches the inputs. The first request or pad enqueue happens at N+1.
- `buf_we` is registered: it fires one cycle after the pop decision.
- `finish` is asserted exactly one cycle after the last `buf_we`.
- Best case (all padding, or zero-latency memory with ready=1): `finish` at N+TileH*TileW+3.
- `start` in any state other than IDLE has no effect, including the DONE cycle.

## Structure
- Shared package `qconv_pkg`: the FSM state enum and the {pad, buf_addr} tag struct.
- The padding and element-to-address computation is local combinational logic.
- One sub-module: `qconv_tag_fifo`, a synchronous FIFO of depth MaxOutstanding with width 1+BufAddrWidth. It has full, empty and show-ahead head outputs and clears on `rst_n`.

## Test plan
- **Interior tile**, TileH=TileW=4, InH=InW=8, Pad=1, ih=iw=1, base=0x100, memory ready=1 with 3-cycle latency → 16 requests at 0x11B..0x11E, 0x123..0x126, 0x12B..0x12E, 0x133..0x136. All 16 buffer writes carry the returned data. One `finish`.
- **Corner tile** ih=iw=0 → 7 zero writes at buf_addr 0,1,2,3,4,8,12. 9 requests, first at 0x100, in raster order. Write order matches buf_addr order.
- **Backpressure**: random `rd_req_ready` and `rd_rsp_valid` with MaxOutstanding=2 → `rd_req_addr` is stable while stalled. No more than 2 requests are in flight. The buffer contents are correct.
- **All-padding tile**, ih=iw=3 → 16 zero writes, no requests. `finish` at N+19.
- **Start while busy**: a second `start` mid-ISSUE → ignored. Exactly 16 writes and one `finish`.
- **Reset mid-DRAIN**: `rst_n` low for 1 cycle → all outputs 0 on the next cycle. No `finish` pulse. A fresh `start` then completes normally.

Source files
------------

// File: rtl/qconv_pkg.sv
// Shared types for the quantized convolution input-fetch path.
package qconv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Widest buffer address a tag can carry; narrower buffers zero-extend.
   localparam int unsigned TagAddrMax = 16;

   typedef struct packed {
      logic                  pad;
      logic [TagAddrMax-1:0] buf_addr;
   } tag_t;

endpackage

// File: rtl/qconv_tag_fifo.sv
// Show-ahead synchronous FIFO holding {pad, buf_addr} tags of in-flight elements.
module qconv_tag_fifo #(
   parameter int Depth = 8,
   parameter int Width = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [PtrW:0]    count;
   logic             do_push;
   logic             do_pop;

   // A pop frees the slot being written, so push on full is legal alongside it.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PtrW+1)'(Depth));
   assign empty = (count == '0);

endmodule

// File: rtl/qconv_read_indata.sv
// Input-tile fetch engine: reads a TileH x TileW tile into the input buffer,
// writing zeros for padding positions, and pulses finish after the last write.
module qconv_read_indata
   import qconv_pkg::*;
#(
   parameter int TileH          = 4,
   parameter int TileW          = 4,
   parameter int InH            = 8,
   parameter int InW            = 8,
   parameter int Pad            = 1,
   parameter int HighBitWidth   = 4,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 64,
   parameter int BufAddrWidth   = $clog2(TileH*TileW),
   parameter int MaxOutstanding = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [HighBitWidth-1:0] ih_high,
   input  logic [HighBitWidth-1:0] iw_high,
   input  logic [AddrWidth-1:0]    base_addr,
   output logic                    rd_req_valid,
   input  logic                    rd_req_ready,
   output logic [AddrWidth-1:0]    rd_req_addr,
   input  logic                    rd_rsp_valid,
   output logic                    rd_rsp_ready,
   input  logic [DataWidth-1:0]    rd_rsp_data,
   output logic                    buf_we,
   output logic [BufAddrWidth-1:0] buf_addr,
   output logic [DataWidth-1:0]    buf_wdata,
   output logic                    finish
);

   localparam int unsigned NumElem = TileH * TileW;
   localparam int MaxT = (TileH > TileW) ? TileH : TileW;
   localparam int CW   = HighBitWidth + $clog2(MaxT) + 2;
   localparam int RW   = (TileH > 1) ? $clog2(TileH) : 1;
   localparam int CoW  = (TileW > 1) ? $clog2(TileW) : 1;
   localparam logic signed [CW-1:0] InHS = CW'(InH);
   localparam logic signed [CW-1:0] InWS = CW'(InW);

   state_t state, state_nxt;

   logic [HighBitWidth-1:0] ih_q;
   logic [HighBitWidth-1:0] iw_q;
   logic [AddrWidth-1:0]    base_q;
   logic [RW-1:0]           r_cnt;
   logic [CoW-1:0]          c_cnt;
   logic [BufAddrWidth-1:0] idx;

   logic signed [CW-1:0]    row_s;
   logic signed [CW-1:0]    col_s;
   logic                    elem_pad;
   logic                    last_elem;
   logic [AddrWidth-1:0]    elem_addr;

   logic                    enq;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   tag_t                    enq_tag;
   tag_t                    head_tag;
   logic [BufAddrWidth:0]   fifo_wdata;
   logic [BufAddrWidth:0]   fifo_head;

   // Element position and padding test for the element currently at the issue point.
   always_comb begin
      row_s     = signed'(CW'(ih_q) * CW'(TileH) + CW'(r_cnt) - CW'(Pad));
      col_s     = signed'(CW'(iw_q) * CW'(TileW) + CW'(c_cnt) - CW'(Pad));
      elem_pad  = (row_s < 0) || (row_s >= InHS) || (col_s < 0) || (col_s >= InWS);
      elem_addr = base_q + AddrWidth'(unsigned'(row_s)) * AddrWidth'(InW)
                         + AddrWidth'(unsigned'(col_s));
      last_elem = (idx == BufAddrWidth'(NumElem - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = ST_ISSUE;
         ST_ISSUE: if (enq && last_elem) state_nxt = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Gating valid on !full keeps it high once raised: only our own enqueue can refill the FIFO.
   always_comb begin
      rd_req_valid = 1'b0;
      enq          = 1'b0;
      finish       = 1'b0;
      unique case (state)
         ST_ISSUE: begin
            rd_req_valid = !elem_pad && !fifo_full;
            enq          = !fifo_full && (elem_pad || rd_req_ready);
         end
         ST_DONE: finish = 1'b1;
         default: ;
      endcase
   end

   assign rd_req_addr = rd_req_valid ? elem_addr : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ih_q   <= '0;
         iw_q   <= '0;
         base_q <= '0;
         r_cnt  <= '0;
         c_cnt  <= '0;
         idx    <= '0;
      end else if (state == ST_IDLE && start) begin
         ih_q   <= ih_high;
         iw_q   <= iw_high;
         base_q <= base_addr;
         r_cnt  <= '0;
         c_cnt  <= '0;
         idx    <= '0;
      end else if (enq) begin
         idx <= idx + 1'b1;
         if (c_cnt == CoW'(TileW - 1)) begin
            c_cnt <= '0;
            r_cnt <= r_cnt + 1'b1;
         end else begin
            c_cnt <= c_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      enq_tag.pad      = elem_pad;
      enq_tag.buf_addr = TagAddrMax'(idx);
      fifo_wdata       = {enq_tag.pad, BufAddrWidth'(enq_tag.buf_addr)};
      head_tag.pad      = fifo_head[BufAddrWidth];
      head_tag.buf_addr = TagAddrMax'(fifo_head[BufAddrWidth-1:0]);
   end

   qconv_tag_fifo #(
      .Depth (MaxOutstanding),
      .Width (BufAddrWidth + 1)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (enq),
      .wdata (fifo_wdata),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rd_rsp_ready = !fifo_empty && !head_tag.pad;
   assign pop          = !fifo_empty && (head_tag.pad || rd_rsp_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= '0;
      end else begin
         buf_we <= pop;
         if (pop) begin
            buf_addr  <= BufAddrWidth'(head_tag.buf_addr);
            buf_wdata <= head_tag.pad ? '0 : rd_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_qconv_read_indata.sv
// Randomized bench for qconv_read_indata against an in-order memory and a tile reference model.
module tb_qconv_read_indata;

   localparam int TH = 4, TW = 4, IH = 8, IW = 8, PD = 1, NE = 16;
   localparam int Lat = 3, Budget = 600, MaxOut = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ih_high = '0;
   logic [3:0]  iw_high = '0;
   logic [31:0] base_addr = '0;
   logic        rd_req_valid;
   logic        rd_req_ready = 1'b0;
   logic [31:0] rd_req_addr;
   logic        rd_rsp_valid = 1'b0;
   logic        rd_rsp_ready;
   logic [63:0] rd_rsp_data = '0;
   logic        buf_we;
   logic [3:0]  buf_addr;
   logic [63:0] buf_wdata;
   logic        finish;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [31:0] mem_q[$];
   int          due_q[$];

   always #5 clk = ~clk;

   qconv_read_indata #(
      .TileH          (TH),
      .TileW          (TW),
      .InH            (IH),
      .InW            (IW),
      .Pad            (PD),
      .MaxOutstanding (MaxOut)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .ih_high      (ih_high),
      .iw_high      (iw_high),
      .base_addr    (base_addr),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_addr  (rd_req_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data  (rd_rsp_data),
      .buf_we       (buf_we),
      .buf_addr     (buf_addr),
      .buf_wdata    (buf_wdata),
      .finish       (finish)
   );

   function automatic logic [63:0] mem_data(input logic [31:0] a);
      return {a * 32'd3 + 32'h1234_5678, ~a};
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_valid"}, rd_req_valid, 0);
      check({tag, "_req_addr"},  rd_req_addr, 0);
      check({tag, "_rsp_ready"}, rd_rsp_ready, 0);
      check({tag, "_buf_we"},    buf_we, 0);
      check({tag, "_buf_addr"},  buf_addr, 0);
      check({tag, "_buf_wdata"}, buf_wdata, 0);
      check({tag, "_finish"},    finish, 0);
   endtask

   // mode 0: normal, 1: extra start while busy, 2: reset during drain
   task automatic run_tile(input int ih, input int iw, input logic [31:0] base,
                           input bit rnd, input int mode);
      logic [31:0] exp_req[$];
      logic [63:0] exp_wd[NE];
      int r, c, row, col;
      int nreq, nwr, nfin, s_cyc, fin_cyc, last_we, max_fl, unstable, zeros, exp_zeros, end_cyc;
      bit stall, did_rst, post_rst;
      logic [31:0] stall_addr, a;

      nreq = 0; nwr = 0; nfin = 0; fin_cyc = -1; last_we = -1; max_fl = 0;
      unstable = 0; zeros = 0; exp_zeros = 0; end_cyc = -1;
      stall = 0; did_rst = 0; post_rst = 0; stall_addr = '0;

      for (int i = 0; i < NE; i++) begin
         r   = i / TW;
         c   = i % TW;
         row = ih * TH + r - PD;
         col = iw * TW + c - PD;
         if (row < 0 || row >= IH || col < 0 || col >= IW) begin
            exp_wd[i] = '0;
            exp_zeros++;
         end else begin
            a = base + 32'(row * IW + col);
            exp_req.push_back(a);
            exp_wd[i] = mem_data(a);
         end
      end

      mem_q.delete();
      due_q.delete();
      start        = 1'b1;
      ih_high      = 4'(ih);
      iw_high      = 4'(iw);
      base_addr    = base;
      rd_req_ready = 1'b0;
      rd_rsp_valid = 1'b0;
      s_cyc        = cyc;
      tick();
      start = 1'b0;

      for (int k = 0; k < Budget; k++) begin
         rst_n = 1'b1;
         start = (mode == 1 && cyc == s_cyc + 5);
         if (start) ih_high = 4'(ih ^ 1);
         rd_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rd_rsp_valid = 1'b0;
         rd_rsp_data  = {$urandom, $urandom};
         if (mode == 2 && !did_rst && nreq == exp_req.size() && nwr < NE) begin
            rst_n   = 1'b0;
            did_rst = 1;
            mem_q.delete();
            due_q.delete();
         end else if (mem_q.size() > 0 && due_q[0] <= cyc && (!rnd || $urandom_range(0, 3) != 0)) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = mem_data(mem_q[0]);
         end
         #1;

         if (post_rst) begin
            check_idle_outputs("after_reset");
            post_rst = 0;
            end_cyc  = cyc + 8;
         end

         if (stall && (!rd_req_valid || rd_req_addr !== stall_addr)) unstable++;
         stall      = rd_req_valid && !rd_req_ready;
         stall_addr = rd_req_addr;

         if (rst_n && rd_req_valid && rd_req_ready) begin
            if (nreq < exp_req.size()) check("req_addr", rd_req_addr, exp_req[nreq]);
            nreq++;
            mem_q.push_back(rd_req_addr);
            due_q.push_back(cyc + Lat);
         end
         if (rd_rsp_valid && rd_rsp_ready) begin
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
         end
         if (mem_q.size() > max_fl) max_fl = mem_q.size();

         if (buf_we) begin
            if (nwr < NE) begin
               check("wr_addr", buf_addr, nwr);
               check("wr_data", buf_wdata, exp_wd[nwr]);
            end
            if (buf_wdata == '0) zeros++;
            last_we = cyc;
            nwr++;
         end
         if (finish) begin
            nfin++;
            fin_cyc = cyc;
            if (end_cyc < 0) end_cyc = cyc + 3;
         end
         if (!rst_n) post_rst = 1;

         tick();
         if (end_cyc >= 0 && cyc > end_cyc) break;
      end

      check("run_terminated", end_cyc >= 0 && cyc > end_cyc, 1);
      if (mode == 2) begin
         check("reset_no_finish", nfin, 0);
      end else begin
         check("finish_count", nfin, 1);
         check("write_count", nwr, NE);
         check("request_count", nreq, exp_req.size());
         check("zero_writes", zeros, exp_zeros);
         check("finish_after_last_we", fin_cyc - last_we, 1);
         check("max_inflight_ok", max_fl <= MaxOut, 1);
         check("req_addr_stable", unstable, 0);
         if (!rnd && exp_req.size() == 0) check("all_pad_latency", fin_cyc - s_cyc, NE + 3);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      run_tile(1, 1, 32'h100, 0, 0);
      run_tile(0, 0, 32'h100, 0, 0);
      run_tile(1, 2, $urandom, 1, 0);
      run_tile(3, 3, 32'h100, 0, 0);
      run_tile(1, 1, 32'h200, 0, 1);
      run_tile(1, 1, 32'h300, 1, 2);
      run_tile(2, 1, 32'h400, 0, 0);
      for (int t = 0; t < 4; t++)
         run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
